// File: rtl/huffman_pkg.sv
// Shared types and elaboration helpers for the parametrised Huffman code builder.
package huffman_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SORT  = 2'd1,
        MERGE = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/huffman_oet_stage.sv
// One odd/even transposition layer: compare-swaps adjacent {count, set} nodes,
// keeping larger counts on top and never swapping equal counts.
module huffman_oet_stage
    import huffman_pkg::*;
#(
    parameter int NSYM = 6,
    parameter int CNTW = 8
) (
    input  logic                       phase,
    input  logic [NSYM-1:0][CNTW-1:0]  cnt_i,
    input  logic [NSYM-1:0][NSYM-1:0]  set_i,
    output logic [NSYM-1:0][CNTW-1:0]  cnt_o,
    output logic [NSYM-1:0][NSYM-1:0]  set_o
);

    always_comb begin
        cnt_o = cnt_i;
        set_o = set_i;
        for (int i = 0; i < NSYM - 1; i++) begin
            if ((i[0] == phase) && (cnt_i[i+1] > cnt_i[i])) begin
                cnt_o[i]   = cnt_i[i+1];
                cnt_o[i+1] = cnt_i[i];
                set_o[i]   = set_i[i+1];
                set_o[i+1] = set_i[i];
            end
        end
    end

endmodule

// File: rtl/huffman_param.sv
// Huffman code builder: counts symbols over a frame, then alternates NSYM-cycle
// sorts with single-cycle merges of the two smallest nonzero nodes.
module huffman_param
    import huffman_pkg::*;
#(
    parameter int NSYM  = 6,
    parameter int CNTW  = 8,
    parameter int CODEW = 8,
    parameter int SYMW  = clog2(NSYM + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    gray_valid,
    input  logic [SYMW-1:0]         gray_data,
    input  logic                    gray_last,
    output logic                    busy,
    output logic                    cnt_valid,
    output logic [NSYM*CNTW-1:0]    cnt,
    output logic                    cnt_sat,
    output logic                    code_valid,
    output logic [NSYM*CODEW-1:0]   hc,
    output logic [NSYM*CODEW-1:0]   m
);

    localparam int              SCW       = clog2(NSYM);
    localparam logic [SCW-1:0]  SORT_LAST = SCW'(NSYM - 1);
    localparam logic [CNTW-1:0] CNT_MAX   = '1;

    state_t                     state_q, state_d;
    logic [SCW-1:0]             sort_cnt_q, sort_cnt_d;
    logic                       first_q, first_d;
    logic                       cnt_valid_q, cnt_valid_d;
    logic                       cnt_sat_q, cnt_sat_d;
    logic [NSYM-1:0][CNTW-1:0]  sym_cnt_q, sym_cnt_d;
    logic [NSYM-1:0][CNTW-1:0]  node_cnt_q, node_cnt_d, sorted_cnt;
    logic [NSYM-1:0][NSYM-1:0]  node_set_q, node_set_d, sorted_set;
    logic [NSYM-1:0][CODEW-1:0] hc_q, hc_d, m_q, m_d;

    logic                       accept;
    int                         nz_nodes;
    int                         code_len;
    logic [NSYM-1:0]            set_hi, set_lo;
    logic [CNTW-1:0]            cnt_hi, cnt_lo, merged_cnt;
    logic [CNTW:0]              sum_full;

    // Samples are taken whenever busy is low, including the single DONE cycle.
    assign accept = gray_valid && ((state_q == IDLE) || (state_q == DONE));

    huffman_oet_stage #(
        .NSYM (NSYM),
        .CNTW (CNTW)
    ) u_oet (
        .phase (sort_cnt_q[0]),
        .cnt_i (node_cnt_q),
        .set_i (node_set_q),
        .cnt_o (sorted_cnt),
        .set_o (sorted_set)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && gray_last) state_d = SORT;
            SORT:    if (sort_cnt_q == SORT_LAST) state_d = (nz_nodes > 1) ? MERGE : DONE;
            MERGE:   state_d = (nz_nodes > 2) ? SORT : DONE;
            DONE:    state_d = (accept && gray_last) ? SORT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        code_valid = 1'b0;
        case (state_q)
            SORT, MERGE: busy       = 1'b1;
            DONE:        code_valid = 1'b1;
            default:     ;
        endcase
    end

    // After a full sort the nonzero nodes sit contiguously at the top.
    always_comb begin
        nz_nodes = 0;
        for (int i = 0; i < NSYM; i++) begin
            if (node_cnt_q[i] != '0) nz_nodes++;
        end
        set_hi = '0;
        set_lo = '0;
        cnt_hi = '0;
        cnt_lo = '0;
        for (int i = 0; i < NSYM; i++) begin
            if (i == nz_nodes - 1) begin
                cnt_lo = node_cnt_q[i];
                set_lo = node_set_q[i];
            end
            if (i == nz_nodes - 2) begin
                cnt_hi = node_cnt_q[i];
                set_hi = node_set_q[i];
            end
        end
        sum_full   = {1'b0, cnt_hi} + {1'b0, cnt_lo};
        merged_cnt = sum_full[CNTW] ? CNT_MAX : sum_full[CNTW-1:0];
    end

    always_comb begin
        sort_cnt_d  = sort_cnt_q;
        first_d     = first_q;
        cnt_valid_d = 1'b0;
        cnt_sat_d   = cnt_sat_q;
        sym_cnt_d   = sym_cnt_q;
        node_cnt_d  = node_cnt_q;
        node_set_d  = node_set_q;
        hc_d        = hc_q;
        m_d         = m_q;
        code_len    = 0;
        if (accept) begin
            if (first_q) begin
                sym_cnt_d = '0;
                cnt_sat_d = 1'b0;
                hc_d      = '0;
                m_d       = '0;
            end
            first_d = 1'b0;
            for (int s = 0; s < NSYM; s++) begin
                if (gray_data == SYMW'(s + 1)) begin
                    if (sym_cnt_d[s] == CNT_MAX) cnt_sat_d = 1'b1;
                    else sym_cnt_d[s] = sym_cnt_d[s] + 1'b1;
                end
            end
            if (gray_last) begin
                first_d     = 1'b1;
                cnt_valid_d = 1'b1;
                sort_cnt_d  = '0;
                node_cnt_d  = sym_cnt_d;
                for (int s = 0; s < NSYM; s++) begin
                    node_set_d[s] = NSYM'(1) << s;
                end
            end
        end else if (state_q == SORT) begin
            node_cnt_d = sorted_cnt;
            node_set_d = sorted_set;
            sort_cnt_d = sort_cnt_q + 1'b1;
            // A lone nonzero symbol never merges, so it gets its one-bit code here.
            if ((sort_cnt_q == SORT_LAST) && (nz_nodes == 1)) begin
                for (int s = 0; s < NSYM; s++) begin
                    if (sym_cnt_q[s] != '0) m_d[s] = CODEW'(1);
                end
            end
        end else if (state_q == MERGE) begin
            sort_cnt_d = '0;
            for (int i = 0; i < NSYM; i++) begin
                if (i == nz_nodes - 1) begin
                    node_cnt_d[i] = merged_cnt;
                    node_set_d[i] = set_hi | set_lo;
                end else if (i == nz_nodes - 2) begin
                    node_cnt_d[i] = '0;
                    node_set_d[i] = '0;
                end
            end
            for (int s = 0; s < NSYM; s++) begin
                if (set_hi[s] || set_lo[s]) begin
                    code_len = 0;
                    for (int b = 0; b < CODEW; b++) begin
                        if (m_q[s][b]) code_len++;
                    end
                    for (int b = 0; b < CODEW; b++) begin
                        if ((b == code_len) && set_lo[s]) hc_d[s][b] = 1'b1;
                    end
                    m_d[s] = (m_q[s] << 1) | CODEW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sort_cnt_q  <= '0;
            first_q     <= 1'b1;
            cnt_valid_q <= 1'b0;
            cnt_sat_q   <= 1'b0;
            sym_cnt_q   <= '0;
            node_cnt_q  <= '0;
            node_set_q  <= '0;
            hc_q        <= '0;
            m_q         <= '0;
        end else begin
            sort_cnt_q  <= sort_cnt_d;
            first_q     <= first_d;
            cnt_valid_q <= cnt_valid_d;
            cnt_sat_q   <= cnt_sat_d;
            sym_cnt_q   <= sym_cnt_d;
            node_cnt_q  <= node_cnt_d;
            node_set_q  <= node_set_d;
            hc_q        <= hc_d;
            m_q         <= m_d;
        end
    end

    assign cnt_valid = cnt_valid_q;
    assign cnt_sat   = cnt_sat_q;
    assign cnt       = sym_cnt_q;
    assign hc        = hc_q;
    assign m         = m_q;

endmodule

// File: tb/tb_huffman_param.sv
// Directed bench for huffman_param: default build plus a CNTW=4 build sharing
// the same input stream, each scenario checked against hand-derived values.
module tb_huffman_param;

    logic        clk;
    logic        reset;
    logic        gray_valid;
    logic [2:0]  gray_data;
    logic        gray_last;

    logic        busy, cnt_valid, cnt_sat, code_valid;
    logic [47:0] dut_cnt;
    logic [47:0] dut_hc, dut_m;

    logic        busy4, cnt_valid4, cnt_sat4, code_valid4;
    logic [23:0] dut_cnt4;
    logic [47:0] dut_hc4, dut_m4;

    int vectors;
    int miscompares;

    huffman_param #(.NSYM(6), .CNTW(8), .CODEW(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .gray_valid (gray_valid),
        .gray_data  (gray_data),
        .gray_last  (gray_last),
        .busy       (busy),
        .cnt_valid  (cnt_valid),
        .cnt        (dut_cnt),
        .cnt_sat    (cnt_sat),
        .code_valid (code_valid),
        .hc         (dut_hc),
        .m          (dut_m)
    );

    huffman_param #(.NSYM(6), .CNTW(4), .CODEW(8)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .gray_valid (gray_valid),
        .gray_data  (gray_data),
        .gray_last  (gray_last),
        .busy       (busy4),
        .cnt_valid  (cnt_valid4),
        .cnt        (dut_cnt4),
        .cnt_sat    (cnt_sat4),
        .code_valid (code_valid4),
        .hc         (dut_hc4),
        .m          (dut_m4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one sample for exactly one rising edge.
    task automatic send(input int sym, input bit last);
        gray_valid = 1'b1;
        gray_data  = 3'(sym);
        gray_last  = last;
        @(posedge clk);
        #1;
        gray_valid = 1'b0;
        gray_last  = 1'b0;
        gray_data  = '0;
    endtask

    // Counts cycles until code_valid of the chosen build, bounded.
    task automatic wait_code(input bit use4, input int start, output int lat);
        lat = start;
        while ((((use4) ? code_valid4 : code_valid) !== 1'b1) && (lat < 400)) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        vectors++;
        if ({busy, cnt_valid, code_valid, cnt_sat} !== 4'b0000) begin
            $display("[TB] FAIL reset_ctrl: got %b, want 0000", {busy, cnt_valid, code_valid, cnt_sat});
            miscompares++;
        end
        vectors++;
        if ({dut_cnt, dut_hc, dut_m} !== '0) begin
            $display("[TB] FAIL reset_bus: cnt=%h hc=%h m=%h, want all 0", dut_cnt, dut_hc, dut_m);
            miscompares++;
        end
    endtask

    task automatic test_canonical();
        int lat;
        for (int i = 0; i < 30; i++) send(1, 1'b0);
        for (int i = 0; i < 25; i++) send(2, 1'b0);
        for (int i = 0; i < 20; i++) send(3, 1'b0);
        for (int i = 0; i < 10; i++) send(4, 1'b0);
        for (int i = 0; i < 10; i++) send(5, 1'b0);
        for (int i = 0; i < 5; i++) send(6, i == 4);
        vectors++;
        if ({cnt_valid, busy} !== 2'b11) begin
            $display("[TB] FAIL t1_cnt_valid: {cnt_valid,busy}=%b, want 11", {cnt_valid, busy});
            miscompares++;
        end
        vectors++;
        if (dut_cnt !== 48'h050A0A14191E) begin
            $display("[TB] FAIL t1_cnt: got %h, want 050a0a14191e", dut_cnt);
            miscompares++;
        end
        wait_code(1'b0, 0, lat);
        vectors++;
        if (lat !== 35) begin
            $display("[TB] FAIL t1_latency: got %0d, want 35", lat);
            miscompares++;
        end
        vectors++;
        if (dut_hc !== 48'h090805030100) begin
            $display("[TB] FAIL t1_hc: got %h, want 090805030100", dut_hc);
            miscompares++;
        end
        vectors++;
        if (dut_m !== 48'h0F0F07030303) begin
            $display("[TB] FAIL t1_m: got %h, want 0f0f07030303", dut_m);
            miscompares++;
        end
        vectors++;
        if ({busy, cnt_sat} !== 2'b00) begin
            $display("[TB] FAIL t1_busy_sat: got %b, want 00", {busy, cnt_sat});
            miscompares++;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        vectors++;
        if ({code_valid, dut_hc, dut_m, dut_cnt} !== {1'b0, 48'h090805030100, 48'h0F0F07030303, 48'h050A0A14191E}) begin
            $display("[TB] FAIL t1_hold: code_valid=%b hc=%h m=%h cnt=%h", code_valid, dut_hc, dut_m, dut_cnt);
            miscompares++;
        end
    endtask

    task automatic test_single_symbol();
        int lat;
        send(3, 1'b0);
        vectors++;
        if ({dut_hc, dut_m, dut_cnt} !== {48'h0, 48'h0, 48'h000000010000}) begin
            $display("[TB] FAIL t3_first_clear: hc=%h m=%h cnt=%h, want 0 0 000000010000", dut_hc, dut_m, dut_cnt);
            miscompares++;
        end
        send(3, 1'b0);
        send(3, 1'b0);
        send(3, 1'b1);
        wait_code(1'b0, 0, lat);
        vectors++;
        if (lat !== 6) begin
            $display("[TB] FAIL t3_latency: got %0d, want 6", lat);
            miscompares++;
        end
        vectors++;
        if ({dut_cnt, dut_hc, dut_m} !== {48'h000000040000, 48'h0, 48'h000000010000}) begin
            $display("[TB] FAIL t3_codes: cnt=%h hc=%h m=%h", dut_cnt, dut_hc, dut_m);
            miscompares++;
        end
    endtask

    task automatic test_uniform();
        int lat;
        int len[6];
        int kraft, n2, n3, bad_shape, bad_prefix;
        logic [7:0] mf, ci, cj;
        for (int s = 1; s <= 6; s++) send(s, s == 6);
        wait_code(1'b0, 0, lat);
        vectors++;
        if (lat !== 35) begin
            $display("[TB] FAIL t2_latency: got %0d, want 35", lat);
            miscompares++;
        end
        kraft = 0;
        n2 = 0;
        n3 = 0;
        bad_shape = 0;
        bad_prefix = 0;
        for (int s = 0; s < 6; s++) begin
            mf = dut_m[s*8 +: 8];
            len[s] = $countones(mf);
            if (mf !== 8'((1 << len[s]) - 1)) bad_shape++;
            if (len[s] == 2) n2++;
            if (len[s] == 3) n3++;
            kraft += 1 << (8 - len[s]);
        end
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++) begin
                if ((i != j) && (len[i] <= len[j])) begin
                    ci = dut_hc[i*8 +: 8];
                    cj = dut_hc[j*8 +: 8] >> (len[j] - len[i]);
                    if (ci == cj) bad_prefix++;
                end
            end
        end
        vectors++;
        if ((n2 !== 2) || (n3 !== 4)) begin
            $display("[TB] FAIL t2_lengths: got %0d of len2 and %0d of len3, want 2 and 4", n2, n3);
            miscompares++;
        end
        vectors++;
        if (kraft !== 256) begin
            $display("[TB] FAIL t2_kraft: got %0d/256, want 256/256", kraft);
            miscompares++;
        end
        vectors++;
        if ((bad_prefix !== 0) || (bad_shape !== 0)) begin
            $display("[TB] FAIL t2_prefix: %0d prefix clashes, %0d bad masks, want 0 and 0", bad_prefix, bad_shape);
            miscompares++;
        end
    endtask

    task automatic test_ignored();
        int lat;
        send(1, 1'b0);
        send(0, 1'b0);
        send(1, 1'b0);
        send(7, 1'b0);
        send(2, 1'b1);
        gray_valid = 1'b1;
        gray_data  = 3'd1;
        gray_last  = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        gray_valid = 1'b0;
        gray_last  = 1'b0;
        gray_data  = '0;
        wait_code(1'b0, 3, lat);
        vectors++;
        if (lat !== 7) begin
            $display("[TB] FAIL t5_latency: got %0d, want 7", lat);
            miscompares++;
        end
        vectors++;
        if (dut_cnt !== 48'h000000000102) begin
            $display("[TB] FAIL t5_cnt: got %h, want 000000000102", dut_cnt);
            miscompares++;
        end
        vectors++;
        if ({dut_hc, dut_m} !== {48'h000000000100, 48'h000000000101}) begin
            $display("[TB] FAIL t5_codes: hc=%h m=%h", dut_hc, dut_m);
            miscompares++;
        end
        send(4, 1'b0);
        send(4, 1'b0);
        send(7, 1'b1);
        vectors++;
        if (cnt_valid !== 1'b1) begin
            $display("[TB] FAIL t5_oor_last: cnt_valid=%b, want 1", cnt_valid);
            miscompares++;
        end
        wait_code(1'b0, 0, lat);
        vectors++;
        if ({lat, dut_cnt, dut_hc, dut_m} !== {32'd6, 48'h000002000000, 48'h0, 48'h000001000000}) begin
            $display("[TB] FAIL t5_oor_frame: lat=%0d cnt=%h hc=%h m=%h", lat, dut_cnt, dut_hc, dut_m);
            miscompares++;
        end
    endtask

    task automatic test_saturation();
        int lat;
        for (int i = 0; i < 20; i++) send(1, 1'b0);
        send(2, 1'b1);
        wait_code(1'b1, 0, lat);
        vectors++;
        if (lat !== 7) begin
            $display("[TB] FAIL t4_latency: got %0d, want 7", lat);
            miscompares++;
        end
        vectors++;
        if ({dut_cnt4, cnt_sat4} !== {24'h00001F, 1'b1}) begin
            $display("[TB] FAIL t4_cnt_sat: cnt=%h sat=%b, want 00001f 1", dut_cnt4, cnt_sat4);
            miscompares++;
        end
        vectors++;
        if ({dut_hc4, dut_m4} !== {48'h000000000100, 48'h000000000101}) begin
            $display("[TB] FAIL t4_codes: hc=%h m=%h", dut_hc4, dut_m4);
            miscompares++;
        end
        vectors++;
        if ({dut_cnt, cnt_sat} !== {48'h000000000114, 1'b0}) begin
            $display("[TB] FAIL t4_wide_cnt: cnt=%h sat=%b, want 000000000114 0", dut_cnt, cnt_sat);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid_sort();
        int lat, pulses;
        send(1, 1'b0);
        send(2, 1'b1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if ({busy, cnt_valid, code_valid, cnt_sat, dut_cnt, dut_hc, dut_m} !== '0) begin
            $display("[TB] FAIL t6_abort: busy=%b cnt=%h hc=%h m=%h", busy, dut_cnt, dut_hc, dut_m);
            miscompares++;
        end
        reset = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (code_valid || cnt_valid || busy) pulses++;
        end
        vectors++;
        if (pulses !== 0) begin
            $display("[TB] FAIL t6_no_pulse: got %0d active cycles, want 0", pulses);
            miscompares++;
        end
        send(5, 1'b0);
        send(5, 1'b0);
        send(5, 1'b0);
        send(6, 1'b1);
        wait_code(1'b0, 0, lat);
        vectors++;
        if ({lat, dut_cnt, dut_hc, dut_m} !== {32'd7, 48'h010300000000, 48'h010000000000, 48'h010100000000}) begin
            $display("[TB] FAIL t6_restart: lat=%0d cnt=%h hc=%h m=%h", lat, dut_cnt, dut_hc, dut_m);
            miscompares++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        gray_valid  = 1'b0;
        gray_data   = '0;
        gray_last   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        test_canonical();
        test_single_symbol();
        test_uniform();
        test_ignored();
        test_saturation();
        test_reset_mid_sort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
